// File: rtl/fm_422_444_if.sv
// ============================================================================
// Module   : fm_422_444_if
// Brief    : YCbCr 4:2:2 in / 4:4:4 out video bus for the chroma upsampler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fm_422_444_if;
  logic       i_de;
  logic       i_hsync;
  logic       i_vsync;
  logic [7:0] i_y;
  logic [7:0] i_c;
  logic       o_de;
  logic       o_hsync;
  logic       o_vsync;
  logic [7:0] o_y;
  logic [7:0] o_cb;
  logic [7:0] o_cr;

  modport master (
    output i_de, i_hsync, i_vsync, i_y, i_c,
    input  o_de, o_hsync, o_vsync, o_y, o_cb, o_cr
  );

  modport slave (
    input  i_de, i_hsync, i_vsync, i_y, i_c,
    output o_de, o_hsync, o_vsync, o_y, o_cb, o_cr
  );
endinterface

`default_nettype wire

// File: rtl/fm_422_444.sv
// ============================================================================
// Module   : fm_422_444
// Brief    : YCbCr 4:2:2 -> 4:4:4 chroma upsampler, fixed 4-cycle latency.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fm_422_444 #(
  parameter bit P_INTERP = 1'b1
) (
  input  logic          clk_v,
  input  logic          rst_x,
  fm_422_444_if.slave   vid
);

  // Stage j holds the input sampled j cycles ago; stage 3 is the pixel being emitted.
  logic [4:1] de_q;
  logic [4:1] hs_q;
  logic [4:1] vs_q;
  logic [3:1] st_q;
  logic [3:1] ph_q;
  logic [7:0] y_q [1:3];
  logic [7:0] c_q [1:4];
  logic [7:0] y_out_q;
  logic [7:0] cb_q;
  logic [7:0] cr_q;

  logic       st_d;
  logic       ph_d;
  logic       nxt1;
  logic       nxt2;
  logic       prv;
  logic [7:0] cb_n;
  logic [7:0] cr_n;
  logic [7:0] cb_d;
  logic [7:0] cr_d;

  // floor((a+b)/2) without a 9-bit intermediate
  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a[7:1]} + {1'b0, b[7:1]} + {7'd0, a[0] & b[0]};
  endfunction

  assign st_d = vid.i_de & ~de_q[1];
  assign ph_d = vid.i_de & de_q[1] & ~ph_q[1];

  assign nxt1 = de_q[2] & ~st_q[2];
  assign nxt2 = nxt1 & de_q[1] & ~st_q[1];
  assign prv  = de_q[4] & ~st_q[3];

  always_comb begin
    cb_d = 8'h00;
    cr_d = 8'h00;
    cb_n = nxt1 ? c_q[2] : c_q[4];
    cr_n = nxt2 ? c_q[1] : c_q[3];
    if (de_q[3]) begin
      if (!ph_q[3]) begin
        cb_d = c_q[3];
        if (nxt1)     cr_d = c_q[2];
        else if (prv) cr_d = c_q[4];
        else          cr_d = 8'h80;
      end else begin
        cb_d = P_INTERP ? avg2(c_q[4], cb_n) : c_q[4];
        cr_d = P_INTERP ? avg2(c_q[3], cr_n) : c_q[3];
      end
    end
  end

  always_ff @(posedge clk_v) begin
    if (rst_x) begin
      de_q    <= '0;
      hs_q    <= '0;
      vs_q    <= '0;
      st_q    <= '0;
      ph_q    <= '0;
      for (int i = 1; i <= 3; i++) y_q[i] <= 8'h00;
      for (int i = 1; i <= 4; i++) c_q[i] <= 8'h00;
      y_out_q <= 8'h00;
      cb_q    <= 8'h00;
      cr_q    <= 8'h00;
    end else begin
      de_q    <= {de_q[3:1], vid.i_de};
      hs_q    <= {hs_q[3:1], vid.i_hsync};
      vs_q    <= {vs_q[3:1], vid.i_vsync};
      st_q    <= {st_q[2:1], st_d};
      ph_q    <= {ph_q[2:1], ph_d};
      y_q[1]  <= vid.i_y;
      y_q[2]  <= y_q[1];
      y_q[3]  <= y_q[2];
      c_q[1]  <= vid.i_c;
      for (int i = 2; i <= 4; i++) c_q[i] <= c_q[i-1];
      y_out_q <= de_q[3] ? y_q[3] : 8'h00;
      cb_q    <= cb_d;
      cr_q    <= cr_d;
    end
  end

  assign vid.o_de    = de_q[4];
  assign vid.o_hsync = hs_q[4];
  assign vid.o_vsync = vs_q[4];
  assign vid.o_y     = y_out_q;
  assign vid.o_cb    = cb_q;
  assign vid.o_cr    = cr_q;

endmodule

`default_nettype wire

// File: tb/tb_fm_422_444.sv
// ============================================================================
// Module   : tb_fm_422_444
// Brief    : Directed bench for fm_422_444 (interpolating and replicating builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fm_422_444;
  logic       clk_v = 1'b0;
  logic       rst_x;
  logic       de, hs, vs;
  logic [7:0] y, c;
  int         n_run  = 0;
  int         n_fail = 0;
  int         n_step = 0;

  // {de, hsync, vsync, y, cb, cr} expected at the outputs, index 3 = due now
  logic [26:0] e1 [0:3];
  logic [26:0] e0 [0:3];
  logic [26:0] obs1, obs0;

  always #5 clk_v = ~clk_v;

  fm_422_444_if vif1 ();
  fm_422_444_if vif0 ();

  assign vif1.i_de = de;  assign vif1.i_hsync = hs;  assign vif1.i_vsync = vs;
  assign vif1.i_y  = y;   assign vif1.i_c     = c;
  assign vif0.i_de = de;  assign vif0.i_hsync = hs;  assign vif0.i_vsync = vs;
  assign vif0.i_y  = y;   assign vif0.i_c     = c;

  fm_422_444 #(.P_INTERP(1'b1)) dut  (.clk_v(clk_v), .rst_x(rst_x), .vid(vif1));
  fm_422_444 #(.P_INTERP(1'b0)) dut0 (.clk_v(clk_v), .rst_x(rst_x), .vid(vif0));

  assign obs1 = {vif1.o_de, vif1.o_hsync, vif1.o_vsync, vif1.o_y, vif1.o_cb, vif1.o_cr};
  assign obs0 = {vif0.o_de, vif0.o_hsync, vif0.o_vsync, vif0.o_y, vif0.o_cb, vif0.o_cr};

  // One input cycle plus its hand-computed 4:4:4 result for each build.
  task automatic step(input logic r, input logic d, input logic h, input logic v,
                      input logic [7:0] yy, input logic [7:0] cc,
                      input logic [7:0] cb1, input logic [7:0] cr1,
                      input logic [7:0] cb0, input logic [7:0] cr0);
    rst_x = r; de = d; hs = h; vs = v; y = yy; c = cc;
    @(posedge clk_v);
    #1;
    n_step++;
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        e1[k] = '0;
        e0[k] = '0;
      end
    end else begin
      for (int k = 3; k > 0; k--) begin
        e1[k] = e1[k-1];
        e0[k] = e0[k-1];
      end
      e1[0] = d ? {1'b1, h, v, yy, cb1, cr1} : {1'b0, h, v, 24'h000000};
      e0[0] = d ? {1'b1, h, v, yy, cb0, cr0} : {1'b0, h, v, 24'h000000};
    end
    n_run++;
    assert (obs1 === e1[3]) else begin
      n_fail++;
      $error("FAIL interp_out step %0d: observed %h expected %h", n_step, obs1, e1[3]);
    end
    n_run++;
    assert (obs0 === e0[3]) else begin
      n_fail++;
      $error("FAIL repl_out step %0d: observed %h expected %h", n_step, obs0, e0[3]);
    end
  endtask

  initial begin
    rst_x = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; y = 8'h00; c = 8'h00;
    // reset and idle
    step(1,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(1,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    // 4-pixel line
    step(0,1,0,0, 8'h10,8'h40, 8'h40,8'h60, 8'h40,8'h60);
    step(0,1,0,0, 8'h20,8'h60, 8'h48,8'h68, 8'h40,8'h60);
    step(0,1,0,0, 8'h30,8'h50, 8'h50,8'h71, 8'h50,8'h71);
    step(0,1,0,0, 8'h40,8'h71, 8'h50,8'h71, 8'h50,8'h71);
    // blanking with hsync and non-zero data on the inputs
    step(0,0,1,0, 8'hAA,8'h55, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,1,0, 8'hAA,8'h55, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,0, 8'hAA,8'h55, 8'h00,8'h00, 8'h00,8'h00);
    // 3-pixel line
    step(0,1,0,0, 8'h11,8'h40, 8'h40,8'h60, 8'h40,8'h60);
    step(0,1,0,0, 8'h22,8'h60, 8'h48,8'h60, 8'h40,8'h60);
    step(0,1,0,0, 8'h33,8'h50, 8'h50,8'h60, 8'h50,8'h60);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,1,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    // 1-pixel line
    step(0,1,0,0, 8'h5A,8'h33, 8'h33,8'h80, 8'h33,8'h80);
    step(0,0,0,1, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,1, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    // saturated chroma must not wrap
    step(0,1,0,0, 8'hFF,8'hFF, 8'hFF,8'hFF, 8'hFF,8'hFF);
    step(0,1,0,0, 8'hFE,8'hFF, 8'hFF,8'hFF, 8'hFF,8'hFF);
    step(0,1,0,0, 8'hFD,8'hFF, 8'hFF,8'hFF, 8'hFF,8'hFF);
    step(0,1,0,0, 8'hFC,8'hFF, 8'hFF,8'hFF, 8'hFF,8'hFF);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    // back-to-back lines with a single blank cycle
    step(0,1,0,0, 8'h10,8'h40, 8'h40,8'h60, 8'h40,8'h60);
    step(0,1,0,0, 8'h20,8'h60, 8'h48,8'h68, 8'h40,8'h60);
    step(0,1,0,0, 8'h30,8'h50, 8'h50,8'h71, 8'h50,8'h71);
    step(0,1,0,0, 8'h40,8'h71, 8'h50,8'h71, 8'h50,8'h71);
    step(0,0,1,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,1,0,0, 8'h05,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,1,0,0, 8'h06,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,1,0,0, 8'h07,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,1,0,0, 8'h08,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    // reset mid-line; i_de stays high so the first post-reset cycle is n=0
    step(0,1,1,1, 8'h91,8'h99, 8'h00,8'h00, 8'h00,8'h00);
    step(0,1,1,1, 8'h92,8'h99, 8'h00,8'h00, 8'h00,8'h00);
    step(1,1,1,1, 8'h93,8'h99, 8'h00,8'h00, 8'h00,8'h00);
    step(0,1,0,0, 8'h01,8'h21, 8'h21,8'h30, 8'h21,8'h30);
    step(0,1,0,0, 8'h02,8'h30, 8'h32,8'h40, 8'h21,8'h30);
    step(0,1,0,0, 8'h03,8'h44, 8'h44,8'h51, 8'h44,8'h51);
    step(0,1,0,0, 8'h04,8'h51, 8'h44,8'h51, 8'h44,8'h51);
    // drain
    for (int i = 0; i < 5; i++)
      step(0,0,0,0, 8'h00,8'h00, 8'h00,8'h00, 8'h00,8'h00);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
